// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, default depth and pointer sizing for the width-converting FIFOs
package fifo_pkg;
   localparam int BYTE_W = 8;
   localparam int WORD_W = 16;
   localparam int DEF_DEPTH = 16;
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/fifo_pack_mem.sv
// fifo_pack_mem: byte-wide register array with one write port and an even/odd read pair
module fifo_pack_mem
   import fifo_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW = ptr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [BYTE_W-1:0] wdata,
   input  logic [AW-2:0]     rpair,
   output logic [BYTE_W-1:0] rdata_lo,
   output logic [BYTE_W-1:0] rdata_hi
);
   logic [BYTE_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata_lo = mem[{rpair, 1'b0}];
   assign rdata_hi = mem[{rpair, 1'b1}];
endmodule

// File: rtl/fifo_pack_8to16.sv
// fifo_pack_8to16: byte-in, 16-bit-word-out show-ahead FIFO over a byte circular buffer
module fifo_pack_8to16
   import fifo_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW = ptr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [BYTE_W-1:0] data_in,
   input  logic              input_valid,
   output logic              input_enable,
   output logic [WORD_W-1:0] data_out,
   output logic              output_valid,
   input  logic              output_enable,
   output logic [AW:0]       level
);
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-2:0] rd_pair_q, rd_pair_d;
   logic [AW:0] level_q, level_d;
   logic wr, rd;
   logic [BYTE_W-1:0] lo, hi;
   assign input_enable = level_q < (AW+1)'(DEPTH);
   assign output_valid = level_q >= (AW+1)'(2);
   assign wr = input_valid && input_enable;
   assign rd = output_enable && output_valid;
   // rd_ptr is kept as a pair index, so it is always even and never straddles the wrap
   assign wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
   assign rd_pair_d = rd ? rd_pair_q + (AW-1)'(1) : rd_pair_q;
   assign level_d = (wr && rd) ? level_q - (AW+1)'(1) :
                    wr ? level_q + (AW+1)'(1) :
                    rd ? level_q - (AW+1)'(2) : level_q;
   always_ff @(posedge clk)
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_pair_q <= '0;
         level_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_pair_q <= rd_pair_d;
         level_q <= level_d;
      end
   fifo_pack_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk(clk),
      .we(wr && rstn),
      .waddr(wr_ptr_q),
      .wdata(data_in),
      .rpair(rd_pair_q),
      .rdata_lo(lo),
      .rdata_hi(hi)
   );
   assign data_out = output_valid ? {hi, lo} : '0;
   assign level = level_q;
endmodule
